// File: rtl/bcci_vout_framer.sv
// bcci_vout_framer: retimes upscaled pixels into a SOF/EOL-framed video stream through a 2-entry output buffer.
module bcci_vout_framer #(
   parameter int AXISOUT_DATA_WIDTH = 32,
   parameter int CHANNEL_WIDTH      = 8,
   parameter int DST_IMG_WIDTH      = 3840,
   parameter int DST_IMG_HEIGHT     = 2160,
   parameter int FRAME_CNT_WIDTH    = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          s_axis_tvalid,
   input  logic [AXISOUT_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                          s_axis_tlast,
   output logic                          s_axis_tready,
   output logic                          m_axis_tvalid,
   output logic [3*CHANNEL_WIDTH-1:0]    m_axis_tdata,
   output logic                          m_axis_tuser,
   output logic                          m_axis_tlast,
   input  logic                          m_axis_tready,
   output logic                          frame_done,
   output logic [FRAME_CNT_WIDTH-1:0]    frame_cnt,
   output logic                          err_eol_early,
   output logic                          err_eol_late,
   input  logic                          err_clr
);
   localparam int PW = 3*CHANNEL_WIDTH;
   localparam int CW = DST_IMG_WIDTH > 1 ? $clog2(DST_IMG_WIDTH) : 1;
   localparam int RW = DST_IMG_HEIGHT > 1 ? $clog2(DST_IMG_HEIGHT) : 1;
   localparam int EW = PW + 3;
   logic [EW-1:0] head_q, head_d, tail_q, tail_d, ent;
   logic v0_q, v0_d, v1_q, v1_d, rdy_q;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic early_q, late_q, fd_q;
   logic [FRAME_CNT_WIDTH-1:0] fcnt_q;
   logic push, pop, at_eol, last_row, eol;
   logic unused_bits;
   assign unused_bits = ^s_axis_tdata;
   assign s_axis_tready = enable && rdy_q;
   assign push     = s_axis_tvalid && s_axis_tready;
   assign pop      = v0_q && m_axis_tready;
   assign at_eol   = col_q == CW'(DST_IMG_WIDTH-1);
   assign last_row = row_q == RW'(DST_IMG_HEIGHT-1);
   assign eol      = at_eol || s_axis_tlast;
   // Entry layout: {pixel, sof, eol, eof}
   assign ent = {s_axis_tdata[PW-1:0], col_q == '0 && row_q == '0, eol, eol && last_row};
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      v0_d   = v0_q;
      v1_d   = v1_q;
      if (pop) begin
         head_d = tail_q;
         v0_d   = v1_q;
         v1_d   = 1'b0;
      end
      if (push && !v0_d) begin
         head_d = ent;
         v0_d   = 1'b1;
      end else if (push) begin
         tail_d = ent;
         v1_d   = 1'b1;
      end
   end
   // An early tlast resyncs to the next line start exactly like a generated EOL
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (push) begin
         col_d = eol ? '0 : col_q + 1'b1;
         row_d = !eol ? row_q : last_row ? '0 : row_q + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         rdy_q   <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         early_q <= 1'b0;
         late_q  <= 1'b0;
         fd_q    <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         v0_q    <= v0_d;
         v1_q    <= v1_d;
         rdy_q   <= !(v0_d && v1_d);
         col_q   <= col_d;
         row_q   <= row_d;
         early_q <= (push && s_axis_tlast && !at_eol) || (early_q && !err_clr);
         late_q  <= (push && at_eol && !s_axis_tlast) || (late_q && !err_clr);
         fd_q    <= pop && head_q[0];
         fcnt_q  <= fcnt_q + FRAME_CNT_WIDTH'(pop && head_q[0]);
      end
   end
   assign m_axis_tvalid = v0_q;
   assign m_axis_tdata  = head_q[EW-1:3];
   assign m_axis_tuser  = head_q[2];
   assign m_axis_tlast  = head_q[1];
   assign frame_done    = fd_q;
   assign frame_cnt     = fcnt_q;
   assign err_eol_early = early_q;
   assign err_eol_late  = late_q;
endmodule

// File: tb/tb_bcci_vout_framer.sv
// tb_bcci_vout_framer: directed table and sequence checks of the video-out framer on an 8x4 frame.
module tb_bcci_vout_framer;
   localparam int W = 8;
   localparam int H = 4;
   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, err_clr = 1'b0;
   logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, m_axis_tready = 1'b0;
   logic [31:0] s_axis_tdata = '0;
   logic s_axis_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done;
   logic err_eol_early, err_eol_late;
   logic [23:0] m_axis_tdata;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   bcci_vout_framer #(.AXISOUT_DATA_WIDTH(32), .CHANNEL_WIDTH(8), .DST_IMG_WIDTH(W),
                      .DST_IMG_HEIGHT(H), .FRAME_CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
      .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .frame_done(frame_done), .frame_cnt(frame_cnt), .err_eol_early(err_eol_early),
      .err_eol_late(err_eol_late), .err_clr(err_clr));

   typedef struct {logic [31:0] d; logic last;} beat_t;
   typedef struct {logic [23:0] d; logic user; logic last;} obeat_t;
   typedef struct {logic v; logic [31:0] d; logic mr; logic e_str; logic e_mv; logic [23:0] e_md; logic e_user;} vec_t;
   beat_t  in_q[$];
   obeat_t exp_q[$], got_q[$];
   int fd_at[$], exp_fd[$];
   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Output monitor: records handshakes and frame_done positions, checks stall stability
   logic prev_stall = 1'b0, prev_fd = 1'b0, seen_edge = 1'b0;
   obeat_t held;
   always @(posedge clk) seen_edge <= rst_n;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall <= 1'b0;
         prev_fd    <= 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", {31'd0, m_axis_tvalid}, 32'd1);
            chk("stall_data", {6'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {6'd0, held.user, held.last, held.d});
         end
         if (frame_done) begin
            fd_at.push_back(got_q.size());
            chk("fd_width", {31'd0, prev_fd}, 32'd0);
         end
         if (m_axis_tvalid && m_axis_tready) got_q.push_back('{m_axis_tdata, m_axis_tuser, m_axis_tlast});
         if (seen_edge && enable && !s_axis_tready) chk("tready_only_when_full", {31'd0, m_axis_tvalid}, 32'd1);
         prev_stall <= m_axis_tvalid && !m_axis_tready;
         held       <= '{m_axis_tdata, m_axis_tuser, m_axis_tlast};
         prev_fd    <= frame_done;
      end
   end

   task automatic add(input int i, input bit lin, input bit user, input bit lout);
      in_q.push_back('{{8'(i*37+5), 24'(i)}, lin});
      exp_q.push_back('{24'(i), user, lout});
   endtask

   task automatic add_frames(input int n);
      for (int i = 0; i < n*W*H; i++) add(i, (i%W) == W-1, (i%(W*H)) == 0, (i%W) == W-1);
   endtask

   task automatic drive(input int gap, input bit tog, input int pause_at);
      int idx = 0, cyc = 0;
      bit acc;
      while (idx < in_q.size() && cyc < 4000) begin
         if (idx == pause_at) begin
            enable = 1'b0;
            s_axis_tvalid = 1'b1;
            s_axis_tdata = in_q[idx].d;
            s_axis_tlast = in_q[idx].last;
            repeat (5) begin
               @(negedge clk);
               chk("enable_low_blocks", {31'd0, s_axis_tready}, 32'd0);
               @(posedge clk); #1;
            end
            enable = 1'b1;
            pause_at = -1;
         end
         s_axis_tvalid = $urandom_range(99) >= gap;
         s_axis_tdata = in_q[idx].d;
         s_axis_tlast = in_q[idx].last;
         m_axis_tready = tog ? ~m_axis_tready : 1'b1;
         @(negedge clk);
         acc = s_axis_tvalid && s_axis_tready;
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      chk("drive_accepted", idx, in_q.size());
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
   endtask

   task automatic drain();
      m_axis_tready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      err_clr = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      enable = 1'b1;
      got_q.delete(); fd_at.delete(); exp_q.delete(); in_q.delete(); exp_fd.delete();
      @(posedge clk); #1;
   endtask

   task automatic cmp_run(input string tag);
      chk({tag, "_beat_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_beat%0d", tag, i), {6'd0, got_q[i].user, got_q[i].last, got_q[i].d},
             {6'd0, exp_q[i].user, exp_q[i].last, exp_q[i].d});
      chk({tag, "_fd_count"}, fd_at.size(), exp_fd.size());
      for (int i = 0; i < exp_fd.size() && i < fd_at.size(); i++)
         chk($sformatf("%s_fd_pos%0d", tag, i), fd_at[i], exp_fd[i]);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_s_tready"}, {31'd0, s_axis_tready}, 32'd0);
      chk({tag, "_m_tvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
      chk({tag, "_m_tdata"}, {8'd0, m_axis_tdata}, 32'd0);
      chk({tag, "_tuser_tlast"}, {30'd0, m_axis_tuser, m_axis_tlast}, 32'd0);
      chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
      chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
      chk({tag, "_errors"}, {30'd0, err_eol_early, err_eol_late}, 32'd0);
   endtask

   vec_t tbl[7];
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
      $fatal(1);
   end

   initial begin
      // Test 1: reset values, cycle-exact fill/stall/drain table, then the rest of the frame
      tbl[0] = '{1'b1, 32'hDE000000, 1'b0, 1'b1, 1'b0, 24'h0, 1'b0};
      tbl[1] = '{1'b1, 32'hDE000001, 1'b0, 1'b1, 1'b1, 24'h0, 1'b1};
      tbl[2] = '{1'b1, 32'hDE000002, 1'b0, 1'b0, 1'b1, 24'h0, 1'b1};
      tbl[3] = '{1'b1, 32'hDE000002, 1'b1, 1'b0, 1'b1, 24'h0, 1'b1};
      tbl[4] = '{1'b1, 32'hDE000002, 1'b1, 1'b1, 1'b1, 24'h1, 1'b0};
      tbl[5] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 24'h2, 1'b0};
      tbl[6] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0};
      rst_n = 1'b0;
      #12;
      chk_reset_outputs("t1_reset");
      do_reset();
      for (int i = 0; i < 7; i++) begin
         s_axis_tvalid = tbl[i].v;
         s_axis_tdata = tbl[i].d;
         s_axis_tlast = 1'b0;
         m_axis_tready = tbl[i].mr;
         @(negedge clk);
         chk($sformatf("tbl%0d_s_tready", i), {31'd0, s_axis_tready}, {31'd0, tbl[i].e_str});
         chk($sformatf("tbl%0d_m_tvalid", i), {31'd0, m_axis_tvalid}, {31'd0, tbl[i].e_mv});
         if (tbl[i].e_mv) begin
            chk($sformatf("tbl%0d_m_tdata", i), {8'd0, m_axis_tdata}, {8'd0, tbl[i].e_md});
            chk($sformatf("tbl%0d_m_tuser", i), {31'd0, m_axis_tuser}, {31'd0, tbl[i].e_user});
         end
         @(posedge clk); #1;
      end
      add_frames(1);
      repeat (3) void'(in_q.pop_front());
      drive(0, 1'b0, -1);
      drain();
      exp_fd.push_back(32);
      cmp_run("t1");
      chk("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
      chk("t1_errors", {30'd0, err_eol_early, err_eol_late}, 32'd0);

      // Test 2: toggling downstream ready and random upstream gaps
      do_reset();
      add_frames(1);
      drive(30, 1'b1, -1);
      drain();
      exp_fd.push_back(32);
      cmp_run("t2");
      chk("t2_frame_cnt", {16'd0, frame_cnt}, 32'd1);
      chk("t2_errors", {30'd0, err_eol_early, err_eol_late}, 32'd0);

      // Test 3: early tlast on the 5th beat of line 0
      do_reset();
      for (int i = 0; i < 29; i++) begin
         if (i < 5) add(i, i == 4, i == 0, i == 4);
         else add(i, ((i-5)%W) == W-1, 1'b0, ((i-5)%W) == W-1);
      end
      drive(0, 1'b0, -1);
      drain();
      exp_fd.push_back(29);
      cmp_run("t3");
      chk("t3_err_early", {31'd0, err_eol_early}, 32'd1);
      chk("t3_err_late", {31'd0, err_eol_late}, 32'd0);
      chk("t3_frame_cnt", {16'd0, frame_cnt}, 32'd1);

      // Test 4: missing tlast, clear, then clear colliding with a new violation
      do_reset();
      for (int i = 0; i < W; i++) add(i, 1'b0, i == 0, i == W-1);
      drive(0, 1'b0, -1);
      drain();
      cmp_run("t4");
      chk("t4_err_late", {31'd0, err_eol_late}, 32'd1);
      chk("t4_err_early", {31'd0, err_eol_early}, 32'd0);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("t4_err_late_cleared", {31'd0, err_eol_late}, 32'd0);
      in_q.delete();
      for (int i = W; i < 2*W-1; i++) add(i, 1'b0, 1'b0, 1'b0);
      drive(0, 1'b0, -1);
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 32'h0000000F;
      s_axis_tlast = 1'b0;
      err_clr = 1'b1;
      @(negedge clk);
      chk("t4_tready_at_violation", {31'd0, s_axis_tready}, 32'd1);
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      err_clr = 1'b0;
      chk("t4_set_wins_over_clear", {31'd0, err_eol_late}, 32'd1);

      // Test 5: finish the frame, send 13 beats, reset mid-frame with the buffer full
      in_q.delete();
      for (int i = 2*W; i < W*H + 13; i++) add(i, (i%W) == W-1, 1'b0, 1'b0);
      drive(0, 1'b0, -1);
      m_axis_tready = 1'b0;
      s_axis_tvalid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      chk("t5_pre_frame_cnt", {16'd0, frame_cnt}, 32'd1);
      chk("t5_pre_m_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t5_async");
      @(negedge clk);
      chk_reset_outputs("t5_held");
      do_reset();
      add_frames(1);
      drive(0, 1'b0, -1);
      drain();
      exp_fd.push_back(32);
      cmp_run("t5");
      chk("t5_frame_cnt", {16'd0, frame_cnt}, 32'd1);

      // Test 6: three frames with enable low mid-line 2
      do_reset();
      add_frames(3);
      drive(0, 1'b0, 2*W+3);
      drain();
      exp_fd.push_back(32);
      exp_fd.push_back(64);
      exp_fd.push_back(96);
      cmp_run("t6");
      chk("t6_frame_cnt", {16'd0, frame_cnt}, 32'd3);
      chk("t6_errors", {30'd0, err_eol_early, err_eol_late}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
